// File: rtl/accel_frame_ctrl.sv
// Frame controller: register slave, result-FIFO drain and bus-master writer with a level irq.
// Optional WAIT_DATA idle timeout is built only when ACCEL_FRAME_CTRL_TIMEOUT_EN is defined.
module accel_frame_ctrl #(
  parameter int LEN_W   = 16,
  parameter int TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [7:0]  s_addr,
  input  logic [3:0]  s_wstrb,
  input  logic [31:0] s_wdata,
  output logic [31:0] s_rdata,
  input  logic        res_empty,
  input  logic [31:0] res_data,
  output logic        res_pop,
  output logic        proc_en,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_wstrb,
  output logic        irq
);

  typedef enum logic [1:0] {IDLE, WAIT_DATA, WRITE, DONE} state_t;

  if (TIMEOUT < 2) begin : g_bad_timeout
    $error("TIMEOUT must be at least 2");
  end

  state_t state, state_nxt;

  logic             irq_en, done_flag, err_flag, abort_pend;
  logic [29:0]      dst_word;
  logic [LEN_W-1:0] len_reg, run_len, count;
  logic [31:0]      cur_addr;
  logic [31:0]      rd_val;
  logic             acc, wr, wr_ctrl, wr_stat, wr_dst, wr_len;
  logic             start_cmd, abort_cmd, hs, last_word, timeout_hit;
  logic             set_done, set_err, load_frame;
  logic [LEN_W-1:0] count_inc;
  logic             busy;

  // A request is accepted on the cycle s_ready rises; ready is then forced low for a cycle.
  assign acc       = s_valid & ~s_ready;
  assign wr        = acc & (|s_wstrb);
  assign wr_ctrl   = wr & (s_addr == 8'h00);
  assign wr_stat   = wr & (s_addr == 8'h04);
  assign wr_dst    = wr & (s_addr == 8'h08);
  assign wr_len    = wr & (s_addr == 8'h0C);
  assign abort_cmd = wr_ctrl & s_wdata[2];
  assign start_cmd = wr_ctrl & s_wdata[0] & ~s_wdata[2];

  assign hs        = (state == WRITE) & m_ready;
  assign count_inc = count + 1'b1;
  assign last_word = (count_inc == run_len);
  assign busy      = (state == WAIT_DATA) | (state == WRITE);

`ifdef ACCEL_FRAME_CTRL_TIMEOUT_EN
  localparam int IW = $clog2(TIMEOUT + 1);
  logic [IW-1:0] idle_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      idle_cnt <= '0;
    else if (state == WAIT_DATA && !res_pop)
      idle_cnt <= idle_cnt + 1'b1;
    else
      idle_cnt <= '0;
  end

  assign timeout_hit = (state == WAIT_DATA) & res_empty & (idle_cnt == IW'(TIMEOUT - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    rd_val = 32'h0;
    case (s_addr)
      8'h00:   rd_val = {30'h0, irq_en, 1'b0};
      8'h04:   rd_val = {29'h0, err_flag, done_flag, busy};
      8'h08:   rd_val = {dst_word, 2'b00};
      8'h0C:   rd_val = 32'(len_reg);
      8'h10:   rd_val = 32'(count);
      default: rd_val = 32'h0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    res_pop    = 1'b0;
    set_done   = 1'b0;
    set_err    = 1'b0;
    load_frame = 1'b0;
    case (state)
      IDLE: begin
        if (start_cmd) begin
          if (len_reg == '0) begin
            set_done = 1'b1;
          end else begin
            load_frame = 1'b1;
            state_nxt  = WAIT_DATA;
          end
        end
      end
      WAIT_DATA: begin
        if (abort_cmd || timeout_hit) begin
          set_err   = 1'b1;
          state_nxt = IDLE;
        end else if (!res_empty) begin
          res_pop   = 1'b1;
          state_nxt = WRITE;
        end
      end
      WRITE: begin
        // An abort seen during WRITE only takes effect once the pending write is acknowledged.
        if (hs) begin
          if (abort_cmd || abort_pend) begin
            set_err   = 1'b1;
            state_nxt = IDLE;
          end else if (last_word) begin
            set_done  = 1'b1;
            state_nxt = DONE;
          end else begin
            state_nxt = WAIT_DATA;
          end
        end
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_ready    <= 1'b0;
      s_rdata    <= 32'h0;
      irq_en     <= 1'b0;
      done_flag  <= 1'b0;
      err_flag   <= 1'b0;
      abort_pend <= 1'b0;
      dst_word   <= '0;
      len_reg    <= '0;
      run_len    <= '0;
      count      <= '0;
      cur_addr   <= 32'h0;
      m_wdata    <= 32'h0;
    end else begin
      s_ready <= acc;
      s_rdata <= acc ? rd_val : 32'h0;
      if (wr_ctrl) irq_en   <= s_wdata[1];
      if (wr_dst)  dst_word <= s_wdata[31:2];
      if (wr_len)  len_reg  <= s_wdata[LEN_W-1:0];
      if (set_done)                     done_flag <= 1'b1;
      else if (wr_stat && s_wdata[1])   done_flag <= 1'b0;
      if (set_err)                      err_flag  <= 1'b1;
      else if (wr_stat && s_wdata[2])   err_flag  <= 1'b0;
      abort_pend <= (state == WRITE) & ~hs & (abort_pend | abort_cmd);
      if (load_frame) begin
        count    <= '0;
        cur_addr <= {dst_word, 2'b00};
        run_len  <= len_reg;
      end else if (hs) begin
        count    <= count_inc;
        cur_addr <= cur_addr + 32'd4;
      end
      if (res_pop) m_wdata <= res_data;
    end
  end

  assign m_valid = (state == WRITE);
  assign m_wstrb = m_valid ? 4'hF : 4'h0;
  assign m_addr  = cur_addr;
  assign proc_en = busy;
  assign irq     = irq_en & (done_flag | err_flag);

endmodule

// File: tb/tb_accel_frame_ctrl.sv
// Scoreboard bench for accel_frame_ctrl: expected bus writes are queued when a frame is issued
// and a monitor compares them against the master port; FIFO and m_ready are randomized.
module tb_accel_frame_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        s_valid, s_ready;
  logic [7:0]  s_addr;
  logic [3:0]  s_wstrb;
  logic [31:0] s_wdata, s_rdata;
  logic        res_empty, res_pop, proc_en;
  logic [31:0] res_data;
  logic        m_valid, m_ready;
  logic [31:0] m_addr, m_wdata;
  logic [3:0]  m_wstrb;
  logic        irq;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t         exp_q[$];
  logic [31:0] fifo_q[$];
  int          checks = 0;
  int          passes = 0;
  int          pops = 0;
  int          ready_mode = 1;
  bit          stall_en = 1'b0;

  always #5 clk = ~clk;

  accel_frame_ctrl dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_addr(s_addr), .s_wstrb(s_wstrb),
    .s_wdata(s_wdata), .s_rdata(s_rdata),
    .res_empty(res_empty), .res_data(res_data), .res_pop(res_pop), .proc_en(proc_en),
    .m_valid(m_valid), .m_ready(m_ready), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_wstrb(m_wstrb), .irq(irq)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // FIFO contents and m_ready are presented on the falling edge.
  always @(negedge clk) begin
    if (ready_mode == 0) m_ready = 1'($urandom_range(0, 1));
    else if (ready_mode == 1) m_ready = 1'b1;
    res_empty = (fifo_q.size() == 0) || (stall_en && $urandom_range(0, 3) == 0);
    res_data  = (fifo_q.size() != 0) ? fifo_q[0] : 32'h0;
  end

  always @(posedge clk) begin
    if (!rst && res_pop) begin
      if (res_empty) chk("pop_while_empty", 32'(res_empty), 32'h0);
      else begin
        void'(fifo_q.pop_front());
        pops++;
      end
    end
    if (!rst && m_valid && m_ready && exp_q.size() != 0) void'(exp_q.pop_front());
  end

  always @(negedge clk) begin
    if (!rst && m_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        $display("[TB] FAIL unexpected_write: got addr %h data %h expected no write", m_addr, m_wdata);
      end else begin
        chk("m_addr", m_addr, exp_q[0].addr);
        chk("m_wdata", m_wdata, exp_q[0].data);
        chk("m_wstrb", 32'(m_wstrb), 32'hF);
      end
    end
  end

  initial begin
    #3_000_000;
    $display("[TB] FAIL global_timeout: got no finish expected finish");
    $fatal(1, "[TB] timeout");
  end

  task automatic bus_access(input logic [7:0] a, input logic [3:0] strb, input logic [31:0] d,
                            output logic [31:0] rd);
    int n = 0;
    @(negedge clk);
    s_valid = 1'b1; s_addr = a; s_wstrb = strb; s_wdata = d;
    do begin
      @(negedge clk);
      n++;
    end while (!s_ready && n < 10);
    if (!s_ready) chk("slave_ready_timeout", 32'(s_ready), 32'h1);
    rd = s_rdata;
    s_valid = 1'b0; s_wstrb = 4'h0;
  endtask

  task automatic bus_write(input logic [7:0] a, input logic [31:0] d);
    logic [31:0] dummy;
    bus_access(a, 4'hF, d, dummy);
  endtask

  task automatic bus_read(input logic [7:0] a, output logic [31:0] d);
    bus_access(a, 4'h0, 32'h0, d);
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (!m_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!m_valid) chk(name, 32'(m_valid), 32'h1);
  endtask

  // Reference model: word i of a frame goes to dst + 4*i (32-bit wrap) with the i-th FIFO word.
  task automatic applyStimulus(input logic [31:0] dst, input int len, input logic [31:0] base,
                               input logic [31:0] ctrl_extra);
    logic [31:0] d;
    bus_write(8'h08, dst);
    bus_write(8'h0C, 32'(len));
    for (int i = 0; i < len; i++) begin
      d = (base != 0) ? base + 32'(i) : $urandom;
      fifo_q.push_back(d);
      exp_q.push_back('{addr: dst + 32'(4 * i), data: d});
    end
    bus_write(8'h00, 32'h1 | ctrl_extra);
  endtask

  task automatic checkOutput(input int len, input int pops_before);
    logic [31:0] st, cnt;
    int n = 0;
    do begin
      bus_read(8'h04, st);
      n++;
    end while (st[0] && n < 500);
    chk("frame_status", st, 32'h2);
    bus_read(8'h10, cnt);
    chk("frame_count", cnt, 32'(len));
    chk("frame_pops", 32'(pops - pops_before), 32'(len));
    chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    chk("proc_en_idle", 32'(proc_en), 32'h0);
    bus_write(8'h04, 32'h2);
  endtask

  initial begin
    logic [31:0] rd, a0, d0;
    int p0;
    rst = 1'b1; s_valid = 1'b0; s_addr = 8'h0; s_wstrb = 4'h0; s_wdata = 32'h0;
    m_ready = 1'b0; res_empty = 1'b1; res_data = 32'h0;
    repeat (3) @(negedge clk);
    chk("rst_s_ready", 32'(s_ready), 32'h0);
    chk("rst_s_rdata", s_rdata, 32'h0);
    chk("rst_m_valid", 32'(m_valid), 32'h0);
    chk("rst_outputs", {res_pop, proc_en, irq, m_wstrb}, 32'h0);
    chk("rst_m_addr_wdata", m_addr | m_wdata, 32'h0);
    rst = 1'b0;
    bus_read(8'h04, rd); chk("rst_status", rd, 32'h0);
    bus_read(8'h10, rd); chk("rst_count", rd, 32'h0);

    $display("[TB] basic frame");
    ready_mode = 1; stall_en = 1'b0; p0 = pops;
    applyStimulus(32'h100, 3, 32'hA1, 32'h0);
    checkOutput(3, p0);

    $display("[TB] zero length with irq");
    bus_write(8'h0C, 32'h0);
    bus_write(8'h00, 32'h3);
    chk("len0_irq_set", 32'(irq), 32'h1);
    bus_read(8'h04, rd); chk("len0_status", rd, 32'h2);
    bus_write(8'h04, 32'h2);
    @(negedge clk);
    chk("len0_irq_clear", 32'(irq), 32'h0);
    bus_write(8'h00, 32'h0);

    $display("[TB] m_ready stall");
    ready_mode = 2; m_ready = 1'b0; p0 = pops;
    applyStimulus(32'h400, 1, 32'h0, 32'h0);
    wait_valid("stall_valid_timeout");
    a0 = m_addr; d0 = m_wdata;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_hold", {31'h0, m_valid}, 32'h1);
      chk("stall_addr_data", m_addr ^ m_wdata, a0 ^ d0);
    end
    m_ready = 1'b1; @(negedge clk); m_ready = 1'b0;
    checkOutput(1, p0);

    $display("[TB] abort during write");
    applyStimulus(32'h800, 4, 32'h0, 32'h0);
    void'(exp_q.pop_back()); void'(exp_q.pop_back());
    wait_valid("abort_w1_timeout");
    m_ready = 1'b1; @(negedge clk); m_ready = 1'b0;
    @(negedge clk);
    wait_valid("abort_w2_timeout");
    bus_write(8'h00, 32'h4);
    chk("abort_pending_valid", 32'(m_valid), 32'h1);
    m_ready = 1'b1; @(negedge clk); m_ready = 1'b0;
    repeat (5) @(negedge clk);
    bus_read(8'h04, rd); chk("abort_status", rd, 32'h4);
    bus_read(8'h10, rd); chk("abort_count", rd, 32'h2);
    chk("abort_proc_en", 32'(proc_en), 32'h0);
    chk("abort_no_more_pops", 32'(fifo_q.size()), 32'h2);
    chk("abort_scoreboard", 32'(exp_q.size()), 32'h0);
    fifo_q.delete();
    bus_write(8'h04, 32'h4);

    $display("[TB] address wrap and random frames");
    ready_mode = 0; stall_en = 1'b1; p0 = pops;
    applyStimulus(32'hFFFF_FFFC, 2, 32'h0, 32'h0);
    checkOutput(2, p0);
    for (int k = 0; k < 6; k++) begin
      p0 = pops;
      applyStimulus($urandom & 32'hFFFF_FFFC, $urandom_range(1, 6), 32'h0, 32'h0);
      checkOutput(int'(exp_q.size()) + 0, p0);
    end

    $display("[TB] empty fifo wait");
    bus_write(8'h0C, 32'h2);
    bus_write(8'h00, 32'h1);
`ifdef ACCEL_FRAME_CTRL_TIMEOUT_EN
    repeat (1100) @(negedge clk);
    bus_read(8'h04, rd); chk("timeout_status", rd, 32'h4);
`else
    repeat (40) @(negedge clk);
    bus_read(8'h04, rd); chk("wait_busy", rd, 32'h1);
    bus_write(8'h00, 32'h4);
    bus_read(8'h04, rd); chk("wait_abort_status", rd, 32'h4);
`endif
    bus_write(8'h04, 32'h4);
    bus_read(8'h04, rd); chk("err_cleared", rd, 32'h0);

    $display("[TB] reset mid-frame");
    ready_mode = 2; m_ready = 1'b0; stall_en = 1'b0;
    applyStimulus(32'h200, 5, 32'h0, 32'h0);
    wait_valid("rstmid_valid_timeout");
    rst = 1'b1;
    #1;
    chk("rstmid_m_valid", 32'(m_valid), 32'h0);
    chk("rstmid_outputs", {res_pop, proc_en, m_wstrb}, 32'h0);
    chk("rstmid_m_addr", m_addr, 32'h0);
    exp_q.delete(); fifo_q.delete();
    @(negedge clk);
    rst = 1'b0; ready_mode = 1; p0 = pops;
    fifo_q.push_back(32'hDEAD_BEEF);
    repeat (10) @(negedge clk);
    chk("rstmid_no_pop", 32'(pops - p0), 32'h0);
    bus_read(8'h10, rd); chk("rstmid_count", rd, 32'h0);
    fifo_q.delete();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/accel_frame_ctrl.md
# accel_frame_ctrl

Frame-level controller for the pixel accelerator at 0x0300_0000. The CPU programs a destination address and a word count through a small register slave. The block then enables the processing pipeline and pops result words from the output FIFO. It writes each word into SoC RAM through a picorv32-style bus master port and raises an interrupt when the frame completes or aborts.

## Interface
Parameters:
- `LEN_W`, 16, width of the LEN and COUNT registers (max frame = 2^LEN_W−1 words)
- `TIMEOUT`, 1024, idle cycles allowed in WAIT_DATA before the frame is aborted (only with the config macro)

Ports:
- `clk` in 1: single clock for all logic
- `rst` in 1: asynchronous, active-high reset
- `s_valid` in 1: register slave request
- `s_ready` out 1: slave acknowledge
- `s_addr` in 8: register byte offset
- `s_wstrb` in 4: nonzero means write, zero means read
- `s_wdata` in 32: write data
- `s_rdata` out 32: read data, valid while `s_ready`=1
- `res_empty` in 1: output FIFO empty
- `res_data` in 32: FIFO head word, valid while `res_empty`=0 (show-ahead)
- `res_pop` out 1: one-cycle FIFO pop
- `proc_en` out 1: enables producer/processor input
- `m_valid` out 1: master write request
- `m_ready` in 1: master acknowledge
- `m_addr` out 32: word-aligned write address
- `m_wdata` out 32: write data
- `m_wstrb` out 4: 4'hF while `m_valid`=1, otherwise 0
- `irq` out 1: level interrupt

## Operation
Registers:
- 0x00 CTRL
  - bit0 START: write-1 pulse
  - bit1 IRQ_EN: read/write
  - bit2 ABORT: write-1 pulse
- 0x04 STATUS
  - bit0 BUSY: read-only
  - bit1 DONE: write-1-to-clear
  - bit2 ERR: write-1-to-clear
- 0x08 DST: bits[1:0] always read as 0
- 0x0C LEN: `LEN_W` bits, zero-extended
- 0x10 COUNT: read-only, words written in the current or last frame
- Unmapped offsets read 0; writes to them are ignored.

FSM states IDLE, WAIT_DATA, WRITE, DONE:
- IDLE + START with LEN=0: set DONE, perform no writes, stay IDLE.
- IDLE + START with LEN≠0:
  - COUNT←0, address←DST, BUSY=1, `proc_en`=1, go to WAIT_DATA.
  - DST/LEN writes while BUSY update the registers but not the running frame's address or length.
- WAIT_DATA with `res_empty`=0: pulse `res_pop` for one cycle, latch `res_data` into `m_wdata`, go to WRITE.
- WRITE: `m_valid`=1 with `m_addr`/`m_wdata` held stable until `m_ready`=1.
  - On handshake: COUNT+1, address+4 (0xFFFF_FFFC wraps to 0).
  - If the new COUNT equals LEN, go to DONE; otherwise go to WAIT_DATA.
- DONE: `proc_en`=0, BUSY=0, set DONE, go to IDLE. Takes one cycle.
- START while BUSY is ignored.
- ABORT while BUSY:
  - From WAIT_DATA: go to IDLE immediately.
  - From WRITE: finish the pending handshake (COUNT updates), then go to IDLE.
  - Either way set ERR, BUSY=0, `proc_en`=0.
  - ABORT in IDLE has no effect.
- ABORT and START written in the same write: ABORT wins.
- `irq` = IRQ_EN & (DONE | ERR).

## Timing
- Reset values: `s_ready`=0, `s_rdata`=0, `res_pop`=0, `proc_en`=0, `m_valid`=0, `m_addr`=0, `m_wdata`=0, `m_wstrb`=0, `irq`=0. All registers reset to 0. State resets to IDLE.
- Slave access:
  - `s_ready` rises one cycle after `s_valid` and lasts one cycle, then is low for at least one cycle.
  - A write takes effect on the `s_ready` cycle.
- Per-word latency: `res_pop` comes 1 cycle after entry to WAIT_DATA with data present. `m_valid` comes the following cycle.
  - Peak throughput is one word per 2 cycles plus `m_ready` latency.
- STATUS.DONE is visible the cycle after the final handshake. `irq` asserts on that same cycle.
- Reset mid-frame: all outputs return to reset values immediately, including dropping `m_valid`. No pop or write is issued afterward.
- DONE/ERR write-1-to-clear in the same cycle as hardware setting them: the set wins.

## Configuration
- `ACCEL_FRAME_CTRL_TIMEOUT_EN` defined:
  - An idle counter runs in WAIT_DATA and is cleared on each pop.
  - When it reaches `TIMEOUT`, the block sets ERR and goes to IDLE, following the abort rules.
- Not defined: no counter; WAIT_DATA waits indefinitely. `TIMEOUT` is unused.

## Test plan
- DST=0x100, LEN=3, START; FIFO supplies 0xA1,0xA2,0xA3 with `m_ready` always 1 → writes to 0x100/0x104/0x108 with those data, `res_pop` ×3, COUNT=3, DONE=1, BUSY=0.
- IRQ_EN=1, LEN=0, START → DONE=1, `irq`=1 next cycle, no `m_valid`; write 0x2 to STATUS → `irq`=0.
- `m_ready` held low 5 cycles during a WRITE → `m_valid`, `m_addr`, `m_wdata` stable all 5 cycles; exactly one COUNT increment.
- ABORT during WRITE of word 2 of LEN=4 → handshake completes, COUNT=2, ERR=1, `proc_en`=0, no further pops.
- DST=0xFFFF_FFFC, LEN=2 → writes to 0xFFFF_FFFC then 0x0000_0000.
- Macro defined, TIMEOUT=16, FIFO kept empty after START → ERR=1 at cycle 16 of WAIT_DATA, BUSY=0. Macro undefined, same stimulus → BUSY stays 1.
